// File: rtl/alu_pipe_param.sv
// alu_pipe_param: single-clock 4-stage pipelined ALU with a register bank,
// a data memory, full operand forwarding and a synchronous read-back port.
// Stage flow: operand select -> S1 (operands) -> S2 (result, zout)
// -> regbank write from S2 -> S3 -> optional memory store from S3.
module alu_pipe_param #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        func,
  input  logic [MEM_AW-1:0] addr,
  input  logic              st_en,
  output logic [DATA_W-1:0] zout,
  output logic              out_valid,
  input  logic [MEM_AW-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int NREG = 2 ** REG_AW;
  localparam int NMEM = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_PASSA = 4'd3,
    OP_PASSB = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_NAND  = 4'd8,
    OP_NOR   = 4'd9,
    OP_XNOR  = 4'd10,
    OP_NOTA  = 4'd11,
    OP_SHR   = 4'd12,
    OP_SHL   = 4'd13,
    OP_ZERO0 = 4'd14,
    OP_ZERO1 = 4'd15
  } op_t;

  // Architectural state
  logic [DATA_W-1:0] regbank [NREG];
  logic [DATA_W-1:0] mem     [NMEM];

  // Stage 1: operands and control of the instruction being executed
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [REG_AW-1:0] s1_rd;
  op_t               s1_func;
  logic [MEM_AW-1:0] s1_addr;
  logic              s1_st;
  logic              s1_v;

  // Stage 2: result waiting for the register-bank write
  logic [DATA_W-1:0] s2_z;
  logic [REG_AW-1:0] s2_rd;
  logic [MEM_AW-1:0] s2_addr;
  logic              s2_st;
  logic              s2_v;

  // Stage 3: result waiting for the optional memory store
  logic [DATA_W-1:0] s3_z;
  logic [MEM_AW-1:0] s3_addr;
  logic              s3_st;
  logic              s3_v;

  logic [DATA_W-1:0] alu_z;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // ALU on the S1 operands; unused codes produce zero
  always_comb begin
    alu_z = '0;
    case (s1_func)
      OP_ADD:   alu_z = s1_a + s1_b;
      OP_SUB:   alu_z = s1_a - s1_b;
      OP_MUL:   alu_z = s1_a * s1_b;
      OP_PASSA: alu_z = s1_a;
      OP_PASSB: alu_z = s1_b;
      OP_AND:   alu_z = s1_a & s1_b;
      OP_OR:    alu_z = s1_a | s1_b;
      OP_XOR:   alu_z = s1_a ^ s1_b;
      OP_NAND:  alu_z = ~(s1_a & s1_b);
      OP_NOR:   alu_z = ~(s1_a | s1_b);
      OP_XNOR:  alu_z = ~(s1_a ^ s1_b);
      OP_NOTA:  alu_z = ~s1_a;
      OP_SHR:   alu_z = s1_a >> 1;
      OP_SHL:   alu_z = s1_a << 1;
      default:  alu_z = '0;
    endcase
  end

  // Operand select: youngest in-flight producer wins, then S2, then the bank
  always_comb begin
    op_a = regbank[rs1];
    op_b = regbank[rs2];
    if (s1_v && (s1_rd == rs1)) begin
      op_a = alu_z;
    end else if (s2_v && (s2_rd == rs1)) begin
      op_a = s2_z;
    end
    if (s1_v && (s1_rd == rs2)) begin
      op_b = alu_z;
    end else if (s2_v && (s2_rd == rs2)) begin
      op_b = s2_z;
    end
  end

  // Valid bits and the visible result; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s2_z <= '0;
    end else begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (s1_v) begin
        s2_z <= alu_z;
      end
    end
  end

  // Data and control fields that travel alongside the valid bits
  always_ff @(posedge clk) begin
    s1_a    <= op_a;
    s1_b    <= op_b;
    s1_rd   <= rd;
    s1_func <= op_t'(func);
    s1_addr <= addr;
    s1_st   <= st_en;
    s2_rd   <= s1_rd;
    s2_addr <= s1_addr;
    s2_st   <= s1_st;
    s3_z    <= s2_z;
    s3_addr <= s2_addr;
    s3_st   <= s2_st;
  end

  // Register bank: reset loads each entry with its own index, S2 writes back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        regbank[k] <= DATA_W'(k);
      end
    end else if (s2_v) begin
      regbank[s2_rd] <= s2_z;
    end
  end

  // Data memory store from S3; contents survive reset but no store happens during it
  always_ff @(posedge clk) begin
    if (s3_v && s3_st && !rst) begin
      mem[s3_addr] <= s3_z;
    end
  end

  // Read-back port, one cycle latency, returns old data on a same-edge write
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
    end else begin
      mem_rdata <= mem[mem_raddr];
    end
  end

  assign zout      = s2_z;
  assign out_valid = s2_v;

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: directed tests for alu_pipe_param at the default widths
// plus a narrow instance (DATA_W=8, REG_AW=3) for truncation behaviour.
module tb_alu_pipe_param;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        st_en;
  logic [15:0] zout;
  logic        out_valid;
  logic [7:0]  mem_raddr;
  logic [15:0] mem_rdata;

  logic        n_in_valid;
  logic [2:0]  n_rs1, n_rs2, n_rd;
  logic [3:0]  n_func;
  logic [7:0]  n_addr;
  logic        n_st_en;
  logic [7:0]  n_zout;
  logic        n_out_valid;
  logic [7:0]  n_mem_raddr;
  logic [7:0]  n_mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] res_q[$];
  logic [7:0]  res8_q[$];

  alu_pipe_param #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .st_en(st_en), .zout(zout), .out_valid(out_valid),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  alu_pipe_param #(.DATA_W(8), .REG_AW(3), .MEM_AW(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd),
    .func(n_func), .addr(n_addr), .st_en(n_st_en), .zout(n_zout), .out_valid(n_out_valid),
    .mem_raddr(n_mem_raddr), .mem_rdata(n_mem_rdata)
  );

  always #5 clk = ~clk;

  // Collect every valid result of both instances, sampled away from the rising edge
  always @(negedge clk) begin
    if (out_valid === 1'b1) res_q.push_back(zout);
    if (n_out_valid === 1'b1) res8_q.push_back(n_zout);
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic [3:0] f, input logic [7:0] ad, input logic st);
    in_valid = 1'b1; rs1 = a; rs2 = b; rd = d; func = f; addr = ad; st_en = st;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                        input logic [3:0] f, input logic [7:0] ad, input logic st);
    n_in_valid = 1'b1; n_rs1 = a; n_rs2 = b; n_rd = d; n_func = f; n_addr = ad; n_st_en = st;
    @(negedge clk);
    n_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    n_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    n_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [15:0] d);
    mem_raddr = a;
    @(negedge clk);
    d = mem_rdata;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (zout !== 16'h0) begin errors++; $display("[TB] FAIL reset_zout: got %0h expected 0", zout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ov: got %0b expected 0", out_valid); end
    checks++; if (mem_rdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %0h expected 0", mem_rdata); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ov8: got %0b expected 0", n_out_valid); end
    issue(4'd15, 4'd0, 4'd15, 4'd3, 8'd0, 1'b0);
    idle(1);
    checks++; if (zout !== 16'd15) begin errors++; $display("[TB] FAIL reset_r15: got %0h expected f", zout); end
  endtask

  task automatic test_single();
    logic [15:0] d;
    do_reset();
    issue(4'd3, 4'd5, 4'd10, 4'd0, 8'd125, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_ov_early: got %0b expected 0", out_valid); end
    idle(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_ov: got %0b expected 1", out_valid); end
    checks++; if (zout !== 16'd8) begin errors++; $display("[TB] FAIL single_zout: got %0h expected 8", zout); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_ov_drop: got %0b expected 0", out_valid); end
    checks++; if (zout !== 16'd8) begin errors++; $display("[TB] FAIL single_zout_hold: got %0h expected 8", zout); end
    idle(2);
    read_mem(8'd125, d);
    checks++; if (d !== 16'd8) begin errors++; $display("[TB] FAIL single_mem125: got %0h expected 8", d); end
    issue(4'd10, 4'd0, 4'd10, 4'd3, 8'd0, 1'b0);
    idle(1);
    checks++; if (zout !== 16'd8) begin errors++; $display("[TB] FAIL single_r10: got %0h expected 8", zout); end
  endtask

  task automatic test_stream();
    logic [15:0] d;
    do_reset();
    issue(4'd3, 4'd8, 4'd12, 4'd2, 8'd126, 1'b1);
    issue(4'd10, 4'd5, 4'd14, 4'd1, 8'd128, 1'b1);
    checks++; if (out_valid !== 1'b1 || zout !== 16'd24) begin errors++; $display("[TB] FAIL stream_mul: got ov=%0b z=%0h expected ov=1 z=18", out_valid, zout); end
    issue(4'd7, 4'd3, 4'd13, 4'd11, 8'd127, 1'b1);
    checks++; if (out_valid !== 1'b1 || zout !== 16'd5) begin errors++; $display("[TB] FAIL stream_sub: got ov=%0b z=%0h expected ov=1 z=5", out_valid, zout); end
    idle(1);
    checks++; if (out_valid !== 1'b1 || zout !== 16'hFFF8) begin errors++; $display("[TB] FAIL stream_nota: got ov=%0b z=%0h expected ov=1 z=fff8", out_valid, zout); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_ov_end: got %0b expected 0", out_valid); end
    idle(2);
    read_mem(8'd126, d);
    checks++; if (d !== 16'd24) begin errors++; $display("[TB] FAIL stream_mem126: got %0h expected 18", d); end
    read_mem(8'd127, d);
    checks++; if (d !== 16'hFFF8) begin errors++; $display("[TB] FAIL stream_mem127: got %0h expected fff8", d); end
    read_mem(8'd128, d);
    checks++; if (d !== 16'd5) begin errors++; $display("[TB] FAIL stream_mem128: got %0h expected 5", d); end
  endtask

  task automatic test_forward();
    logic [15:0] exp_f [4] = '{16'd3, 16'd6, 16'd9, 16'd3};
    logic [15:0] got;
    for (int g = 0; g < 4; g++) begin
      do_reset();
      res_q.delete();
      issue(4'd1, 4'd2, 4'd4, 4'd0, 8'd0, 1'b0);
      idle(g);
      issue(4'd4, 4'd4, 4'd5, 4'd0, 8'd0, 1'b0);
      idle(g);
      issue(4'd4, 4'd5, 4'd6, 4'd0, 8'd0, 1'b0);
      idle(g + 1);
      issue(4'd4, 4'd0, 4'd7, 4'd0, 8'd0, 1'b0);
      idle(4);
      checks++; if (res_q.size() != 4) begin errors++; $display("[TB] FAIL fwd_count gap=%0d: got %0d expected 4", g, res_q.size()); end
      for (int i = 0; i < 4; i++) begin
        got = (i < res_q.size()) ? res_q[i] : 16'hxxxx;
        checks++; if (got !== exp_f[i]) begin errors++; $display("[TB] FAIL fwd_res gap=%0d idx=%0d: got %0h expected %0h", g, i, got, exp_f[i]); end
      end
    end
  endtask

  task automatic test_funcs();
    logic [15:0] exp_f [16] = '{16'h16, 16'h2, 16'h78, 16'hC, 16'hA, 16'h8, 16'hE, 16'h6,
                                16'hFFF7, 16'hFFF1, 16'hFFF9, 16'hFFF3, 16'h6, 16'h18, 16'h0, 16'h0};
    logic [15:0] got;
    do_reset();
    res_q.delete();
    for (int f = 0; f < 16; f++) issue(4'd12, 4'd10, 4'd15, 4'(f), 8'd0, 1'b0);
    idle(4);
    checks++; if (res_q.size() != 16) begin errors++; $display("[TB] FAIL func_count: got %0d expected 16", res_q.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < res_q.size()) ? res_q[i] : 16'hxxxx;
      checks++; if (got !== exp_f[i]) begin errors++; $display("[TB] FAIL func_%0d: got %0h expected %0h", i, got, exp_f[i]); end
    end
  endtask

  task automatic test_width();
    logic [15:0] exp_w [5] = '{16'hFFFF, 16'h0001, 16'hFFFE, 16'hFFFE, 16'h7FFF};
    logic [15:0] got;
    do_reset();
    res_q.delete();
    issue(4'd0, 4'd0, 4'd1, 4'd11, 8'd0, 1'b0);
    issue(4'd1, 4'd1, 4'd2, 4'd2, 8'd0, 1'b0);
    issue(4'd3, 4'd5, 4'd8, 4'd1, 8'd0, 1'b0);
    issue(4'd1, 4'd0, 4'd9, 4'd13, 8'd0, 1'b0);
    issue(4'd1, 4'd0, 4'd10, 4'd12, 8'd0, 1'b0);
    idle(4);
    checks++; if (res_q.size() != 5) begin errors++; $display("[TB] FAIL width_count: got %0d expected 5", res_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < res_q.size()) ? res_q[i] : 16'hxxxx;
      checks++; if (got !== exp_w[i]) begin errors++; $display("[TB] FAIL width_%0d: got %0h expected %0h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_narrow();
    logic [7:0] exp_n [13] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                               8'hFF, 8'h01, 8'hFE, 8'hFE, 8'h7F};
    logic [7:0] got;
    do_reset();
    res8_q.delete();
    for (int k = 0; k < 8; k++) issue8(3'(k), 3'd0, 3'(k), 4'd3, 8'd0, 1'b0);
    issue8(3'd0, 3'd0, 3'd1, 4'd11, 8'd200, 1'b1);
    issue8(3'd1, 3'd1, 3'd2, 4'd2, 8'd0, 1'b0);
    issue8(3'd3, 3'd5, 3'd6, 4'd1, 8'd0, 1'b0);
    issue8(3'd1, 3'd0, 3'd7, 4'd13, 8'd0, 1'b0);
    issue8(3'd1, 3'd0, 3'd4, 4'd12, 8'd0, 1'b0);
    idle(4);
    checks++; if (res8_q.size() != 13) begin errors++; $display("[TB] FAIL narrow_count: got %0d expected 13", res8_q.size()); end
    for (int i = 0; i < 13; i++) begin
      got = (i < res8_q.size()) ? res8_q[i] : 8'hxx;
      checks++; if (got !== exp_n[i]) begin errors++; $display("[TB] FAIL narrow_%0d: got %0h expected %0h", i, got, exp_n[i]); end
    end
    n_mem_raddr = 8'd200;
    @(negedge clk);
    checks++; if (n_mem_rdata !== 8'hFF) begin errors++; $display("[TB] FAIL narrow_mem200: got %0h expected ff", n_mem_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    do_reset();
    issue(4'd9, 4'd9, 4'd1, 4'd2, 8'd0, 1'b0);
    issue(4'd1, 4'd4, 4'd2, 4'd0, 8'd130, 1'b1);
    idle(4);
    read_mem(8'd130, d);
    checks++; if (d !== 16'h55) begin errors++; $display("[TB] FAIL rmid_prefill: got %0h expected 55", d); end
    do_reset();
    res_q.delete();
    in_valid = 1'b1; rs1 = 4'd12; rs2 = 4'd13; rd = 4'd11; func = 4'd0; addr = 8'd130; st_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    checks++; if (res_q.size() != 0) begin errors++; $display("[TB] FAIL rmid_ov: got %0d valid results expected 0", res_q.size()); end
    checks++; if (zout !== 16'h0) begin errors++; $display("[TB] FAIL rmid_zout: got %0h expected 0", zout); end
    read_mem(8'd130, d);
    checks++; if (d !== 16'h55) begin errors++; $display("[TB] FAIL rmid_mem130: got %0h expected 55", d); end
    issue(4'd11, 4'd0, 4'd11, 4'd3, 8'd0, 1'b0);
    idle(1);
    checks++; if (zout !== 16'd11) begin errors++; $display("[TB] FAIL rmid_r11: got %0h expected b", zout); end
  endtask

  task automatic test_nostore();
    logic [15:0] d;
    logic [15:0] got;
    do_reset();
    issue(4'd7, 4'd0, 4'd7, 4'd0, 8'd140, 1'b1);
    idle(4);
    res_q.delete();
    issue(4'd2, 4'd3, 4'd9, 4'd0, 8'd140, 1'b0);
    idle(5);
    checks++; if (res_q.size() != 1) begin errors++; $display("[TB] FAIL nost_ov_cycles: got %0d expected 1", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : 16'hxxxx;
    checks++; if (got !== 16'd5) begin errors++; $display("[TB] FAIL nost_zout: got %0h expected 5", got); end
    read_mem(8'd140, d);
    checks++; if (d !== 16'd7) begin errors++; $display("[TB] FAIL nost_mem140: got %0h expected 7", d); end
    issue(4'd9, 4'd0, 4'd9, 4'd3, 8'd0, 1'b0);
    idle(1);
    checks++; if (zout !== 16'd5) begin errors++; $display("[TB] FAIL nost_r9: got %0h expected 5", zout); end
  endtask

  task automatic test_read_during_write();
    mem_raddr = 8'd140;
    idle(1);
    issue(4'd1, 4'd2, 4'd3, 4'd0, 8'd140, 1'b1);
    idle(3);
    checks++; if (mem_rdata !== 16'd7) begin errors++; $display("[TB] FAIL rdw_old: got %0h expected 7", mem_rdata); end
    idle(1);
    checks++; if (mem_rdata !== 16'd3) begin errors++; $display("[TB] FAIL rdw_new: got %0h expected 3", mem_rdata); end
  endtask

  // Drive defaults, run every scenario in order, then report
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0; st_en = 1'b0; mem_raddr = '0;
    n_in_valid = 1'b0; n_rs1 = '0; n_rs2 = '0; n_rd = '0; n_func = '0; n_addr = '0; n_st_en = 1'b0; n_mem_raddr = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_forward();
    test_funcs();
    test_width();
    test_narrow();
    test_reset_mid();
    test_nostore();
    test_read_during_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
